// File: rtl/vc_buffer_param_if.sv
// Purpose: flit bus between link receiver and the VC input buffer.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready on both the fill and drain sides.
//
// Port summary: vc_id_i/fdata_i/valid_i/ready_o form the fill side;
// fdata_o/valid_o/ready_i form the drain side; vc_id_o, ocup_o and
// error_o report buffer status. master drives the inputs, slave is the buffer.
interface vc_buffer_param_if #(
    parameter int FLIT_W  = 34,
    parameter int DEPTH   = 4,
    parameter int VC_ID_W = 2
);
    localparam int OCUP_W = $clog2(DEPTH) + 1;

    logic [VC_ID_W-1:0] vc_id_i;
    logic [VC_ID_W-1:0] vc_id_o;
    logic [FLIT_W-1:0]  fdata_i;
    logic               valid_i;
    logic               ready_o;
    logic [FLIT_W-1:0]  fdata_o;
    logic               valid_o;
    logic               ready_i;
    logic [OCUP_W-1:0]  ocup_o;
    logic               error_o;

    modport master (
        output vc_id_i, fdata_i, valid_i, ready_i,
        input  vc_id_o, ready_o, fdata_o, valid_o, ocup_o, error_o
    );

    modport slave (
        input  vc_id_i, fdata_i, valid_i, ready_i,
        output vc_id_o, ready_o, fdata_o, valid_o, ocup_o, error_o
    );
endinterface

// File: rtl/vc_buffer_param.sv
// Purpose: DEPTH-entry input VC flit buffer with head/tail packet locking.
// Latency: 1 cycle fill-to-drain (0 when empty with VC_BUFFER_BYPASS_EN).
// Backpressure: ready_o low when full or a new head arrives mid-packet.
//
// Ports: clk, arst (synchronous, active-high), bus (vc_buffer_param_if.slave).
// Optional feature macro: VC_BUFFER_BYPASS_EN -- an accepted flit arriving at
// an empty buffer with ready_i high goes straight to fdata_o without storage.
module vc_buffer_param #(
    parameter int FLIT_W  = 34,
    parameter int DEPTH   = 4,
    parameter int VC_ID_W = 2
) (
    input  logic                clk,
    input  logic                arst,
    vc_buffer_param_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [FLIT_W-1:0]  mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      ocup_q;
    logic [VC_ID_W-1:0] vc_id_q, vc_id_d;
    logic               error_q, error_d;

    logic [1:0]         ftype;
    logic               is_head, is_tail;
    logic               empty, full;
    logic               accept, orphan, bypass, push, pop;

    assign ftype   = bus.fdata_i[FLIT_W-1 -: 2];
    assign is_head = (ftype == 2'b00);
    assign is_tail = (ftype == 2'b11);

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Only a head is held off by the lock; body/tail must always drain in.
    assign bus.ready_o = !full && !(is_head && (state_q == LOCKED));

    assign accept = bus.valid_i && bus.ready_o;
    // Body/tail outside a packet: consumed from the link but discarded.
    assign orphan = accept && !is_head && (state_q == IDLE);

`ifdef VC_BUFFER_BYPASS_EN
    assign bypass = accept && !orphan && empty && bus.ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !orphan && !bypass;
    assign pop  = !empty && bus.ready_i;

    assign bus.valid_o = !empty || bypass;
    assign bus.fdata_o = bypass ? bus.fdata_i :
                         (empty ? '0 : mem_q[rd_ptr_q[AW-1:0]]);
    assign bus.ocup_o  = ocup_q;
    assign bus.vc_id_o = vc_id_q;
    assign bus.error_o = error_q;

    always_comb begin
        state_d  = state_q;
        vc_id_d  = vc_id_q;
        error_d  = orphan;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        if (accept && !orphan) begin
            if (is_head) begin
                state_d = LOCKED;
                vc_id_d = bus.vc_id_i;
            end else if (is_tail) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ocup_q   <= '0;
            vc_id_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ocup_q   <= wr_ptr_d - rd_ptr_d;
            vc_id_q  <= vc_id_d;
            error_q  <= error_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.fdata_i;
        end
    end
endmodule

// File: tb/tb_vc_buffer_param.sv
module tb_vc_buffer_param;
    localparam int FLIT_W  = 34;
    localparam int DEPTH   = 4;
    localparam int VC_ID_W = 2;
`ifdef VC_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [1:0] HEAD = 2'b00;
    localparam logic [1:0] BODY = 2'b01;
    localparam logic [1:0] TAIL = 2'b11;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    vc_buffer_param_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .VC_ID_W(VC_ID_W)) bus ();

    vc_buffer_param #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .VC_ID_W(VC_ID_W)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    // Reference model: a plain queue of stored flits plus packet-level state.
    logic [FLIT_W-1:0]  mq[$];
    bit                 m_locked;
    logic [VC_ID_W-1:0] m_vc;
    bit                 m_err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_locked = 1'b0;
        m_vc     = '0;
        m_err    = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input bit rst, input bit v, input logic [1:0] ty,
                         input logic [VC_ID_W-1:0] vc, input bit rdy);
        logic [63:0]       r;
        logic [FLIT_W-1:0] f;
        logic [FLIT_W-1:0] exp_dat;
        bit                is_head, acc, orph, byp, exp_rdy, exp_vld;
        int                n;
        r = {$urandom(), $urandom()};
        f = r[FLIT_W-1:0];
        f[FLIT_W-1 -: 2] = ty;
        arst        = rst;
        bus.valid_i = v;
        bus.fdata_i = f;
        bus.vc_id_i = vc;
        bus.ready_i = rdy;
        @(negedge clk);
        n       = mq.size();
        is_head = (ty == HEAD);
        exp_rdy = (n < DEPTH) && !(is_head && m_locked);
        acc     = v && exp_rdy;
        orph    = acc && !is_head && !m_locked;
        byp     = BYP && acc && !orph && (n == 0) && rdy;
        exp_vld = (n > 0) || byp;
        exp_dat = byp ? f : ((n > 0) ? mq[0] : '0);
        chk("ready_o", 64'(bus.ready_o), 64'(exp_rdy));
        chk("valid_o", 64'(bus.valid_o), 64'(exp_vld));
        chk("fdata_o", 64'(bus.fdata_o), 64'(exp_dat));
        chk("ocup_o",  64'(bus.ocup_o),  64'(n));
        chk("vc_id_o", 64'(bus.vc_id_o), 64'(m_vc));
        chk("error_o", 64'(bus.error_o), 64'(m_err));
        if (rst) begin
            model_reset();
        end else begin
            if (rdy && n > 0) void'(mq.pop_front());
            m_err = orph;
            if (acc && !orph) begin
                if (!byp) mq.push_back(f);
                if (is_head) begin
                    m_locked = 1'b1;
                    m_vc     = vc;
                end else if (ty == TAIL) begin
                    m_locked = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst        = 1'b1;
        bus.valid_i = 1'b1;
        bus.fdata_i = '0;
        bus.vc_id_i = 2'd3;
        bus.ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_ocup",  64'(bus.ocup_o),  64'd0);
        chk("rst_fdata", 64'(bus.fdata_o), 64'd0);
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_vc",    64'(bus.vc_id_o), 64'd0);
        model_reset();

        // Fill to full with drain stalled, then drain in order.
        cycle(0, 1, HEAD, 2'd2, 0);
        cycle(0, 1, BODY, 2'd0, 0);
        cycle(0, 1, BODY, 2'd0, 0);
        cycle(0, 1, TAIL, 2'd0, 0);
        chk("fill_ocup",  64'(bus.ocup_o),  64'(DEPTH));
        chk("fill_ready", 64'(bus.ready_o), 64'd0);
        chk("fill_vc",    64'(bus.vc_id_o), 64'd2);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, HEAD, 2'd0, 1);
            chk("drain_ocup", 64'(bus.ocup_o), 64'(3 - i));
        end

        // A second head waits until the current packet's tail is in.
        cycle(0, 1, HEAD, 2'd1, 0);
        cycle(0, 1, HEAD, 2'd3, 0);
        chk("lock_ready", 64'(bus.ready_o), 64'd0);
        cycle(0, 1, BODY, 2'd0, 1);
        cycle(0, 1, TAIL, 2'd0, 1);
        cycle(0, 1, HEAD, 2'd3, 1);
        chk("lock_vc", 64'(bus.vc_id_o), 64'd3);
        cycle(0, 1, TAIL, 2'd0, 1);
        repeat (4) cycle(0, 0, HEAD, 2'd0, 1);

        // Orphan body: dropped, one-cycle error pulse.
        cycle(0, 1, BODY, 2'd0, 0);
        chk("orph_err",  64'(bus.error_o), 64'd1);
        chk("orph_ocup", 64'(bus.ocup_o),  64'd0);
        cycle(0, 0, HEAD, 2'd0, 0);
        chk("orph_err_clr", 64'(bus.error_o), 64'd0);

        // Simultaneous push/pop at 2, then push refused at full despite pop.
        cycle(0, 1, HEAD, 2'd1, 0);
        cycle(0, 1, BODY, 2'd0, 0);
        cycle(0, 1, BODY, 2'd0, 1);
        chk("pushpop_ocup", 64'(bus.ocup_o), 64'd2);
        cycle(0, 1, BODY, 2'd0, 0);
        cycle(0, 1, BODY, 2'd0, 0);
        cycle(0, 1, TAIL, 2'd0, 1);
        chk("full_pushpop", 64'(bus.ocup_o), 64'(DEPTH - 1));
        cycle(0, 1, TAIL, 2'd0, 1);
        repeat (4) cycle(0, 0, HEAD, 2'd0, 1);

        // Empty buffer, head with drain ready: bypass or one-cycle latency.
        cycle(0, 1, HEAD, 2'd2, 1);
        chk("byp_ocup", 64'(bus.ocup_o), BYP ? 64'd0 : 64'd1);
        cycle(0, 1, TAIL, 2'd0, 1);
        repeat (2) cycle(0, 0, HEAD, 2'd0, 1);

        // Reset mid-packet discards contents and unlocks.
        cycle(0, 1, HEAD, 2'd1, 0);
        cycle(0, 1, BODY, 2'd0, 0);
        cycle(1, 0, HEAD, 2'd0, 0);
        chk("midrst_ocup", 64'(bus.ocup_o), 64'd0);
        cycle(0, 1, BODY, 2'd0, 0);
        chk("midrst_orph", 64'(bus.error_o), 64'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            int          t;
            logic [1:0]  ty;
            t  = $urandom_range(0, 99);
            ty = (t < 30) ? HEAD : (t < 55) ? TAIL : (t < 78) ? BODY : 2'b10;
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 75), ty,
                  VC_ID_W'($urandom_range(0, (1 << VC_ID_W) - 1)),
                  ($urandom_range(0, 99) < 65));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
